// File: rtl/y86_fetch_queue.sv
// Y86-64 fetch unit: PC, byte-wide imem, length decode into a decoded-instruction FIFO.
// Optional taken-prediction for conditional jXX under `Y86_FETCH_PREDICT_EN.
module y86_fetch_queue #(
  parameter int          IMEM_BYTES = 128,
  parameter int          QDEPTH     = 4,
  parameter logic [63:0] RESET_PC   = 64'd0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_BYTES)-1:0] imem_waddr,
  input  logic [7:0]                    imem_wdata,
  input  logic                          redirect_valid,
  input  logic [63:0]                   redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [3:0]                    out_icode,
  output logic [3:0]                    out_ifun,
  output logic [3:0]                    out_rA,
  output logic [3:0]                    out_rB,
  output logic [63:0]                   out_valC,
  output logic [63:0]                   out_valP,
  output logic [63:0]                   out_pc,
  output logic [1:0]                    out_stat,
  output logic [63:0]                   fetch_pc,
  output logic [$clog2(QDEPTH):0]       q_count
);

  localparam int AW = $clog2(IMEM_BYTES);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_AOK = 2'd0;
  localparam logic [1:0] ST_HLT = 2'd1;
  localparam logic [1:0] ST_ADR = 2'd2;
  localparam logic [1:0] ST_INS = 2'd3;

  typedef enum logic {RUN, STOP} state_t;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] pc;
    logic [1:0]  stat;
  } entry_t;

  state_t        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  entry_t        fifo_q [QDEPTH];
  logic          fifo_we;

  logic [7:0]    imem_q [IMEM_BYTES];

  always_ff @(posedge clk) begin
    if (imem_we) imem_q[imem_waddr] <= imem_wdata;
  end

  // Longest instruction is 10 bytes; read them all and flag any out of range.
  logic [64:0] faddr [10];
  logic [7:0]  fbyte [10];
  logic [9:0]  oob;

  always_comb begin
    for (int i = 0; i < 10; i++) begin
      faddr[i] = {1'b0, fetch_pc_q} + 65'(i);
      oob[i]   = (faddr[i] >= 65'(IMEM_BYTES));
      fbyte[i] = imem_q[faddr[i][AW-1:0]];
    end
  end

  logic [3:0]  icode, ifun, len;
  logic        has_regs, ins, adr, halt, stop_fetch;
  logic [9:0]  len_mask;
  logic [63:0] valc, valp, npc;
  entry_t      ent;

  always_comb begin
    icode    = fbyte[0][7:4];
    ifun     = fbyte[0][3:0];
    len      = 4'd1;
    has_regs = 1'b0;
    valc     = '0;
    case (icode)
      4'h2, 4'h6, 4'hA, 4'hB: begin
        len      = 4'd2;
        has_regs = 1'b1;
      end
      4'h3, 4'h4, 4'h5: begin
        len      = 4'd10;
        has_regs = 1'b1;
        valc     = {fbyte[9], fbyte[8], fbyte[7], fbyte[6],
                    fbyte[5], fbyte[4], fbyte[3], fbyte[2]};
      end
      4'h7, 4'h8: begin
        len  = 4'd9;
        valc = {fbyte[8], fbyte[7], fbyte[6], fbyte[5],
                fbyte[4], fbyte[3], fbyte[2], fbyte[1]};
      end
      default: ;
    endcase

    ins  = (icode > 4'hB);
    halt = (icode == 4'h0);
    for (int i = 0; i < 10; i++) len_mask[i] = (4'(i) < len);
    adr  = |(oob & len_mask);
    valp = fetch_pc_q + 64'(len);
    stop_fetch = adr | ins | halt;

    ent    = '0;
    ent.pc = fetch_pc_q;
    npc    = fetch_pc_q;
    if (adr) begin
      ent.stat = ST_ADR;
    end else begin
      ent.icode = icode;
      ent.ifun  = ifun;
      ent.ra    = has_regs ? fbyte[1][7:4] : 4'hF;
      ent.rb    = has_regs ? fbyte[1][3:0] : 4'hF;
      ent.valc  = valc;
      ent.valp  = valp;
      ent.stat  = ins ? ST_INS : (halt ? ST_HLT : ST_AOK);
      npc       = valp;
      if (icode == 4'h8) begin
        npc = valc;
      end else if (icode == 4'h7 && ifun == 4'h0) begin
        npc = valc;
`ifdef Y86_FETCH_PREDICT_EN
      end else if (icode == 4'h7) begin
        npc = valc;
`endif
      end
    end
  end

  logic pop, push;

  always_comb begin
    pop        = out_valid & out_ready;
    push       = (state_q == RUN) && ((count_q < CW'(QDEPTH)) || pop);
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    fifo_we    = 1'b0;
    // Redirect wins over everything, including a same-cycle pop.
    if (redirect_valid) begin
      state_d    = RUN;
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      rd_d       = '0;
      wr_d       = '0;
    end else begin
      if (push) begin
        fifo_we    = 1'b1;
        wr_d       = wr_q + PW'(1);
        fetch_pc_d = npc;
        if (stop_fetch) state_d = STOP;
      end
      if (pop) rd_d = rd_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      if (fifo_we) fifo_q[wr_q] <= ent;
    end
  end

  entry_t head;
  assign head      = fifo_q[rd_q];
  assign out_valid = (count_q != '0);
  assign out_icode = head.icode;
  assign out_ifun  = head.ifun;
  assign out_rA    = head.ra;
  assign out_rB    = head.rb;
  assign out_valC  = head.valc;
  assign out_valP  = head.valp;
  assign out_pc    = head.pc;
  assign out_stat  = head.stat;
  assign fetch_pc  = fetch_pc_q;
  assign q_count   = count_q;

endmodule

// File: tb/tb_y86_fetch_queue.sv
// Scoreboard bench for y86_fetch_queue: directed programs, expected entries queued by stimulus,
// popped and compared by a monitor whenever the DUT hands over an entry.
module tb_y86_fetch_queue;

  localparam int AW = 7;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] pc;
    logic [1:0]  stat;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_we = 1'b0;
  logic [AW-1:0] imem_waddr = '0;
  logic [7:0]    imem_wdata = '0;
  logic          redirect_valid = 1'b0;
  logic [63:0]   redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    out_icode, out_ifun, out_rA, out_rB;
  logic [63:0]   out_valC, out_valP, out_pc, fetch_pc;
  logic [1:0]    out_stat;
  logic [2:0]    q_count;

  int tests = 0;
  int fails = 0;
  ent_t exp_q[$];
  ent_t act_e, exp_e;

  y86_fetch_queue #(.IMEM_BYTES(128), .QDEPTH(4), .RESET_PC(64'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_icode(out_icode), .out_ifun(out_ifun), .out_rA(out_rA), .out_rB(out_rB),
    .out_valC(out_valC), .out_valP(out_valP), .out_pc(out_pc), .out_stat(out_stat),
    .fetch_pc(fetch_pc), .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic ent_t mk(input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [63:0] vc, input logic [63:0] vp,
                              input logic [63:0] pc, input logic [1:0] st);
    ent_t e;
    e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
    e.valc = vc; e.valp = vp; e.pc = pc; e.stat = st;
    return e;
  endfunction

  // Monitor: every accepted head is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      act_e = mk(out_icode, out_ifun, out_rA, out_rB, out_valC, out_valP, out_pc, out_stat);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got pc=%0d icode=%h stat=%0d, required no entry",
                 act_e.pc, act_e.icode, act_e.stat);
      end else begin
        exp_e = exp_q.pop_front();
        if (act_e !== exp_e) begin
          fails++;
          $display("FAIL sb_entry: got pc=%0d ic=%h fn=%h rA=%h rB=%h valC=%0d valP=%0d stat=%0d, required pc=%0d ic=%h fn=%h rA=%h rB=%h valC=%0d valP=%0d stat=%0d",
                   act_e.pc, act_e.icode, act_e.ifun, act_e.ra, act_e.rb, act_e.valc, act_e.valp, act_e.stat,
                   exp_e.pc, exp_e.icode, exp_e.ifun, exp_e.ra, exp_e.rb, exp_e.valc, exp_e.valp, exp_e.stat);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    imem_we    = 1'b1;
    imem_waddr = AW'(a);
    imem_wdata = d;
    tick(1);
    imem_we    = 1'b0;
  endtask

  // Hold reset and clear the whole memory to halt bytes.
  task automatic fill_under_reset();
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 128; i++) wr(i, 8'h00);
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_q_count", 64'(q_count), 64'd0);
    chk("rst_fetch_pc", fetch_pc, 64'd0);
    chk("rst_out_icode", 64'(out_icode), 64'd0);
    chk("rst_out_valC", out_valC, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);

    // nop; irmovq $255,%rdx; halt
    fill_under_reset();
    wr(0, 8'h10); wr(1, 8'h30); wr(2, 8'hF2); wr(3, 8'hFF);
    exp_q.push_back(mk(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 64'd0, 2'd0));
    exp_q.push_back(mk(4'h3, 4'h0, 4'hF, 4'h2, 64'd255, 64'd11, 64'd1, 2'd0));
    exp_q.push_back(mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd12, 64'd11, 2'd1));
    out_ready = 1'b1;
    rst_n = 1'b1;
    tick(10);
    chk("prog1_fetch_pc", fetch_pc, 64'd12);
    chk("prog1_q_count", 64'(q_count), 64'd0);
    chk("prog1_drained", 64'(exp_q.size()), 64'd0);

    // Eight nops with backpressure, then drain
    fill_under_reset();
    for (int i = 0; i < 8; i++) begin
      wr(i, 8'h10);
      exp_q.push_back(mk(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'(i + 1), 64'(i), 2'd0));
    end
    exp_q.push_back(mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd9, 64'd8, 2'd1));
    rst_n = 1'b1;
    tick(6);
    chk("full_q_count", 64'(q_count), 64'd4);
    chk("full_fetch_pc", fetch_pc, 64'd4);
    out_ready = 1'b1;
    tick(9);
    chk("drain_rate", 64'(exp_q.size()), 64'd0);
    chk("drain_q_count", 64'(q_count), 64'd0);
    chk("drain_fetch_pc", fetch_pc, 64'd9);

    // jmp 41; je 52 at 41
    fill_under_reset();
    wr(0, 8'h70); wr(1, 8'd41); wr(41, 8'h73); wr(42, 8'h34);
    exp_q.push_back(mk(4'h7, 4'h0, 4'hF, 4'hF, 64'd41, 64'd9, 64'd0, 2'd0));
    exp_q.push_back(mk(4'h7, 4'h3, 4'hF, 4'hF, 64'd52, 64'd50, 64'd41, 2'd0));
`ifdef Y86_FETCH_PREDICT_EN
    exp_q.push_back(mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd53, 64'd52, 2'd1));
`else
    exp_q.push_back(mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd51, 64'd50, 2'd1));
`endif
    out_ready = 1'b1;
    rst_n = 1'b1;
    tick(10);
    chk("je_drained", 64'(exp_q.size()), 64'd0);
`ifdef Y86_FETCH_PREDICT_EN
    chk("je_fetch_pc", fetch_pc, 64'd53);
`else
    chk("je_fetch_pc", fetch_pc, 64'd51);
`endif

    // Invalid instruction at 5, then redirect back to 0
    fill_under_reset();
    for (int i = 0; i < 5; i++) wr(i, 8'h10);
    wr(5, 8'hC0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++)
        exp_q.push_back(mk(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'(i + 1), 64'(i), 2'd0));
      exp_q.push_back(mk(4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd6, 64'd5, 2'd3));
    end
    out_ready = 1'b1;
    rst_n = 1'b1;
    tick(12);
    chk("ins_stop_fetch_pc", fetch_pc, 64'd6);
    chk("ins_stop_q_count", 64'(q_count), 64'd0);
    chk("ins_first_pass", 64'(exp_q.size()), 64'd6);
    redirect_to(64'd0);
    chk("ins_redir_fetch_pc", fetch_pc, 64'd0);
    chk("ins_redir_q_count", 64'(q_count), 64'd0);
    tick(10);
    chk("ins_second_pass", 64'(exp_q.size()), 64'd0);

    // Address errors: irmovq straddling the end, then jump to 200
    fill_under_reset();
    wr(0, 8'h70); wr(1, 8'd120); wr(120, 8'h30); wr(121, 8'hF2);
    exp_q.push_back(mk(4'h7, 4'h0, 4'hF, 4'hF, 64'd120, 64'd9, 64'd0, 2'd0));
    exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd120, 2'd2));
    out_ready = 1'b1;
    rst_n = 1'b1;
    tick(8);
    chk("adr120_drained", 64'(exp_q.size()), 64'd0);
    wr(1, 8'd200);
    exp_q.push_back(mk(4'h7, 4'h0, 4'hF, 4'hF, 64'd200, 64'd9, 64'd0, 2'd0));
    exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd200, 2'd2));
    redirect_to(64'd0);
    tick(8);
    chk("adr200_drained", 64'(exp_q.size()), 64'd0);

    // Redirect with a full queue and a same-cycle pop
    fill_under_reset();
    for (int i = 0; i < 8; i++) wr(i, 8'h10);
    exp_q.push_back(mk(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 64'd0, 2'd0));
    rst_n = 1'b1;
    tick(6);
    chk("flush_pre_q_count", 64'(q_count), 64'd4);
    out_ready = 1'b1;
    redirect_to(64'd20);
    chk("flush_q_count", 64'(q_count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_fetch_pc", fetch_pc, 64'd20);
    exp_q.push_back(mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd21, 64'd20, 2'd1));
    tick(5);
    chk("flush_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-operation
    fill_under_reset();
    for (int i = 0; i < 4; i++) wr(i, 8'h10);
    rst_n = 1'b1;
    tick(3);
    chk("arst_pre_q_count", 64'(q_count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q_count", 64'(q_count), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_fetch_pc", fetch_pc, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
